// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads,
// parks a fetched word while the hazard unit stalls, applies EX/MEM
// redirects and fills the IF/ID latch.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        pcstall,
    input  logic        ifid_enable,
    input  logic        ifid_nop,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [1:0]  jump_sel,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic        halt,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_npc_q, buf_npc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_npc_q, ifid_npc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        accept;
    logic [31:0] pc_next;

    // Redirect detection and target selection (JR > J > branch); 2'b11 is ignored
    always_comb begin
        redirect = ((jump_sel == 2'b01) || (jump_sel == 2'b10) || branch_taken)
                   && (state_q != HALTED);
        if (jump_sel == 2'b10) begin
            redirect_target = jr_target;
        end else if (jump_sel == 2'b01) begin
            redirect_target = jump_target;
        end else begin
            redirect_target = branch_target;
        end
    end

    // Next-state, PC, hold buffer and IF/ID latch update
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_instr_d   = buf_instr_q;
        buf_npc_d     = buf_npc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_npc_d    = ifid_npc_q;
        ifid_valid_d  = ifid_valid_q;
        fetch_count_d = fetch_count_q;
        pc_next       = pc_q + PC_STEP;
        accept        = !pcstall && ifid_enable && !ifid_nop;

        if (redirect) begin
            pc_d         = redirect_target;
            buf_instr_d  = '0;
            buf_npc_d    = '0;
            ifid_instr_d = '0;
            ifid_npc_d   = '0;
            ifid_valid_d = 1'b0;
            state_d      = FETCH;
        end else if (state_q == HALTED || halt) begin
            // The halt edge itself already behaves like HALTED: nothing new is delivered
            ifid_instr_d = '0;
            ifid_npc_d   = '0;
            ifid_valid_d = 1'b0;
            buf_instr_d  = '0;
            buf_npc_d    = '0;
            state_d      = HALTED;
        end else begin
            case (state_q)
                FETCH: begin
                    if (ihit && accept) begin
                        ifid_instr_d  = imemload;
                        ifid_npc_d    = pc_next;
                        ifid_valid_d  = 1'b1;
                        pc_d          = pc_next;
                        fetch_count_d = fetch_count_q + 32'd1;
                    end else if (ihit) begin
                        // Word arrived but IF/ID cannot take it: park it, stop reading
                        buf_instr_d = imemload;
                        buf_npc_d   = pc_next;
                        state_d     = HOLD;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        ifid_instr_d  = buf_instr_q;
                        ifid_npc_d    = buf_npc_q;
                        ifid_valid_d  = 1'b1;
                        pc_d          = pc_next;
                        fetch_count_d = fetch_count_q + 32'd1;
                        buf_instr_d   = '0;
                        buf_npc_d     = '0;
                        state_d       = FETCH;
                    end
                end
                default: state_d = HALTED;
            endcase

            if (ifid_nop) begin
                ifid_instr_d = '0;
                ifid_npc_d   = '0;
                ifid_valid_d = 1'b0;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= FETCH;
            pc_q          <= PC_INIT;
            buf_instr_q   <= '0;
            buf_npc_q     <= '0;
            ifid_instr_q  <= '0;
            ifid_npc_q    <= '0;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_instr_q   <= buf_instr_d;
            buf_npc_q     <= buf_npc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_npc_q    <= ifid_npc_d;
            ifid_valid_q  <= ifid_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imemREN     = (state_q == FETCH);
    assign imemaddr    = pc_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_npc    = ifid_npc_q;
    assign ifid_valid  = ifid_valid_q;
    assign fetch_count = fetch_count_q;

endmodule
